// File: rtl/bambu_main_pkg.sv
// Shared constants, FSM state type and address-decode helpers for the bambu_main kernel.
package bambu_main_pkg;

    localparam int N      = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2R  = 3'd2,
        P2W  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Byte address of word idx inside an array placed at base.
    function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base + {{(32-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

    // Arrays are private RAMs, so the base only cancels out here.
    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/bambu_main_ram_sp.sv
// Synchronous single-port 16 x 32 RAM with registered read data (1-cycle latency).
module main_ram_sp
    import bambu_main_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately unreset; every word is written before it is read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bambu_main.sv
// HLS-style kernel: phase 1 fills A/B, phase 2 combines them into C/D and returns a checksum.
module bambu_main
    import bambu_main_pkg::*;
#(
    parameter int unsigned MEM_var_419652_419512 = 4096,
    parameter int unsigned MEM_var_419678_419512 = 4096,
    parameter int unsigned MEM_var_420284_419532 = 4096,
    parameter int unsigned MEM_var_420408_419532 = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_port,
    output logic              done_port,
    output logic [DATA_W-1:0] return_port
);

    localparam logic [31:0] BASE_A = 32'(MEM_var_419652_419512);
    localparam logic [31:0] BASE_B = 32'(MEM_var_419678_419512);
    localparam logic [31:0] BASE_C = 32'(MEM_var_420284_419532);
    localparam logic [31:0] BASE_D = 32'(MEM_var_420408_419532);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] ret_q, ret_d;

    logic              a_we_s, b_we_s, c_we_s, d_we_s;
    logic [IDX_W-1:0]  b_idx_s;
    logic [IDX_W-1:0]  addr_a_s, addr_b_s, addr_c_s, addr_d_s;
    logic [DATA_W-1:0] rd_a_s, rd_b_s;
    logic [DATA_W-1:0] c_rd_unused_s, d_rd_unused_s;
    logic [DATA_W-1:0] k_s, sq_s, sum_s;

    assign k_s   = DATA_W'(idx_q) + 32'd1;
    assign sq_s  = k_s * k_s;
    assign sum_s = rd_b_s + rd_a_s;

    // B is read back in reverse order during phase 2.
    assign b_idx_s  = (state_q == P2R) ? (IDX_LAST - idx_q) : idx_q;
    assign addr_a_s = word_index(byte_addr(BASE_A, idx_q), BASE_A);
    assign addr_b_s = word_index(byte_addr(BASE_B, b_idx_s), BASE_B);
    assign addr_c_s = word_index(byte_addr(BASE_C, idx_q), BASE_C);
    assign addr_d_s = word_index(byte_addr(BASE_D, idx_q), BASE_D);

    main_ram_sp u_ram_a (.clk_i(clock), .we_i(a_we_s), .addr_i(addr_a_s), .wdata_i(k_s),    .rdata_o(rd_a_s));
    main_ram_sp u_ram_b (.clk_i(clock), .we_i(b_we_s), .addr_i(addr_b_s), .wdata_i(sq_s),   .rdata_o(rd_b_s));
    main_ram_sp u_ram_c (.clk_i(clock), .we_i(c_we_s), .addr_i(addr_c_s), .wdata_i(rd_b_s), .rdata_o(c_rd_unused_s));
    main_ram_sp u_ram_d (.clk_i(clock), .we_i(d_we_s), .addr_i(addr_d_s), .wdata_i(sum_s),  .rdata_o(d_rd_unused_s));

    // Next-state, datapath and RAM write-enable decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        ret_d   = ret_q;
        a_we_s  = 1'b0;
        b_we_s  = 1'b0;
        c_we_s  = 1'b0;
        d_we_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_port) begin
                    idx_d   = 4'd0;
                    acc_d   = 32'd0;
                    state_d = P1;
                end else begin
                    state_d = IDLE;
                end
            end
            P1: begin
                a_we_s = 1'b1;
                b_we_s = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = 4'd0;
                    state_d = P2R;
                end else begin
                    idx_d   = idx_q + 4'd1;
                end
            end
            P2R: begin
                state_d = P2W;
            end
            P2W: begin
                c_we_s = 1'b1;
                d_we_s = 1'b1;
                acc_d  = acc_q + sum_s;
                if (idx_q == IDX_LAST) begin
                    done_d  = 1'b1;
                    ret_d   = acc_q + sum_s;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = P2R;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            acc_q   <= 32'd0;
            done_q  <= 1'b0;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            ret_q   <= ret_d;
        end
    end

    assign done_port   = done_q;
    assign return_port = ret_q;

endmodule

// File: tb/tb_bambu_main.sv
// Randomized bench for bambu_main against a cycle-count reference model of the start/done contract.
module tb_bambu_main;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_port = 1'b0;
    logic        done_port;
    logic [31:0] return_port;

    int checks = 0;
    int errors = 0;
    bit sim_end = 1'b0;

    bit          busy_m = 1'b0;
    int          cnt_m = 0;
    logic        done_m = 1'b0;
    logic [31:0] ret_m = 32'd0;
    int          model_done_cnt = 0;
    int          dut_done_cnt = 0;

    always #5 clock = ~clock;

    bambu_main dut (
        .clock       (clock),
        .reset       (reset),
        .start_port  (start_port),
        .done_port   (done_port),
        .return_port (return_port)
    );

    // Checksum straight from the algorithm: C gets B reversed, D gets B+A, acc sums D.
    function automatic logic [31:0] expected_checksum();
        logic [31:0] a [16];
        logic [31:0] b [16];
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 16; k++) begin
            a[k] = 32'(k + 1);
            b[k] = 32'((k + 1) * (k + 1));
        end
        for (int k = 0; k < 16; k++) s += b[15 - k] + a[k];
        return s;
    endfunction

    // Contract model: a run lasts 49 edges after the accepting edge, done in the last one.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            cnt_m  <= 0;
            done_m <= 1'b0;
            ret_m  <= 32'd0;
        end else if (!busy_m) begin
            done_m <= 1'b0;
            if (start_port) begin
                busy_m <= 1'b1;
                cnt_m  <= 0;
            end
        end else begin
            cnt_m  <= cnt_m + 1;
            done_m <= (cnt_m == 47);
            if (cnt_m == 47) ret_m <= expected_checksum();
            if (cnt_m == 48) busy_m <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : compare
        chk("model_pin", expected_checksum(), 32'd1632);
        forever begin
            @(negedge clock or negedge reset or posedge sim_end);
            if (sim_end) break;
            if (!reset) #1;
            chk("done_port", {31'd0, done_port}, {31'd0, done_m});
            chk("return_port", return_port, ret_m);
            if (done_port === 1'b1) dut_done_cnt++;
            if (done_m) model_done_cnt++;
        end
        chk("done_count", 32'(dut_done_cnt), 32'(model_done_cnt));
        chk("min_runs", {31'd0, (model_done_cnt >= 6)}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    initial begin : stimulus
        #1 reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(20);

        start_port = 1'b1;
        cycles(1);
        for (int c = 0; c < 45; c++) begin
            start_port = ($urandom_range(0, 3) == 0);
            cycles(1);
        end
        start_port = 1'b0;
        cycles(60);

        start_port = 1'b1;
        cycles(160);
        start_port = 1'b0;
        cycles(60);

        start_port = 1'b1;
        cycles(1);
        start_port = 1'b0;
        cycles($urandom_range(17, 45));
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(5);
        start_port = 1'b1;
        cycles(1);
        start_port = 1'b0;
        cycles(60);

        for (int c = 0; c < 400; c++) begin
            start_port = ($urandom_range(0, 9) == 0);
            reset      = !($urandom_range(0, 149) == 0);
            cycles(1);
        end
        reset      = 1'b1;
        start_port = 1'b1;
        cycles(1);
        start_port = 1'b0;
        cycles(60);
        sim_end = 1'b1;
    end

endmodule
